// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_t  : responder FSM states
//   dmem_map_t    : result of a byte-address to word-index translation
//   addr_to_index : translates a byte address into a word index plus range flag
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] index;
        logic              in_range;
    } dmem_map_t;

    // Unsigned 32-bit arithmetic: an address below the base wraps to a huge
    // offset, and the explicit base compare flags it as out of range.
    function automatic dmem_map_t addr_to_index(input logic [WORD_W-1:0] addr,
                                                input logic [WORD_W-1:0] base,
                                                input logic [WORD_W-1:0] depth);
        dmem_map_t m;
        m.index    = (addr - base) >> 2;
        m.in_range = (addr >= base) && (m.index < depth);
        return m;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the memory controller
// (master) and the responder (slave).
//   Address/WriteData/ReadEnable/WriteEnable/ByteEnable : request, master -> slave
//   ReadData/Ack/Error/Busy                             : response, slave -> master
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] Address;
    logic [WORD_W-1:0] WriteData;
    logic              ReadEnable;
    logic              WriteEnable;
    logic [BE_W-1:0]   ByteEnable;
    logic [WORD_W-1:0] ReadData;
    logic              Ack;
    logic              Error;
    logic              Busy;

    modport master (
        output Address, WriteData, ReadEnable, WriteEnable, ByteEnable,
        input  ReadData, Ack, Error, Busy
    );

    modport slave (
        input  Address, WriteData, ReadEnable, WriteEnable, ByteEnable,
        output ReadData, Ack, Error, Busy
    );

endinterface

// File: rtl/data_mem_responder_byte_ram.sv
// DEPTH_WORDS x 32 synchronous RAM with per-byte write lanes, one read port
// and one write port. Contents are not reset.
//   clk_i                         : clock
//   wr_en_i/wr_idx_i/wr_be_i/wr_data_i : write port, lanes with wr_be_i=1 update
//   rd_en_i/rd_idx_i              : read port, registered read when rd_en_i=1
//   rd_data_o                     : last word read, held while rd_en_i=0
module byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [BE_W-1:0]   wr_be_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory port. Captures one read or write
// request, waits LATENCY cycles, then pulses Ack for one cycle with ReadData
// (reads) or Error (illegal requests). Writes commit at the end of the Ack
// cycle.
//   CLK  : clock, rising edge
//   RST  : synchronous reset, active low
//   dmem : request/response bundle (slave side)
//
// state | meaning
// IDLE  | waiting for ReadEnable|WriteEnable; captures the request
// WAIT  | counting down wait states, inputs ignored, Busy=1
// RESP  | Ack cycle; write lanes commit at the edge leaving this state
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_mem_responder_if.slave  dmem
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    // Forces ReadData to zero after reset and after an error response;
    // cleared when a legal read loads the RAM output register.
    logic              zero_q, zero_d;

    logic              req;
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    dmem_map_t         req_map;
    logic              unused_idx_hi;

    logic              ram_rd_en;
    logic [IDX_W-1:0]  ram_rd_idx;
    logic              ram_wr_en;
    logic [WORD_W-1:0] ram_rd_data;

    // Response attributes at the edge entering RESP: taken straight from the
    // inputs when LATENCY is 0, otherwise from the request registers.
    logic              resp_err;
    logic              resp_rd;

    assign req           = dmem.ReadEnable | dmem.WriteEnable;
    assign req_map       = addr_to_index(dmem.Address, BASE_ADDR, WORD_W'(DEPTH_WORDS));
    assign req_idx       = req_map.index[IDX_W-1:0];
    assign unused_idx_hi = ^req_map.index[WORD_W-1:IDX_W];
    assign req_err       = (dmem.ReadEnable & dmem.WriteEnable) | ~req_map.in_range;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        err_d      = err_q;
        ack_d      = 1'b0;
        error_d    = 1'b0;
        busy_d     = 1'b0;
        zero_d     = zero_q;
        ram_rd_en  = 1'b0;
        ram_rd_idx = idx_q;
        ram_wr_en  = 1'b0;
        resp_err   = err_q;
        resp_rd    = ~wr_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = dmem.WriteData;
                    be_d    = dmem.ByteEnable;
                    wr_d    = dmem.WriteEnable & ~dmem.ReadEnable;
                    err_d   = req_err;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        resp_err   = req_err;
                        resp_rd    = ~dmem.WriteEnable;
                        ram_rd_idx = req_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        busy_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            RESP: begin
                state_d   = IDLE;
                ram_wr_en = wr_q & ~err_q & RST;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != RESP && state_d == RESP) begin
            ack_d     = 1'b1;
            error_d   = resp_err;
            ram_rd_en = ~resp_err & resp_rd;
            if (resp_err) begin
                zero_d = 1'b1;
            end else if (resp_rd) begin
                zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            zero_q  <= zero_d;
        end
    end

    byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i     (CLK),
        .wr_en_i   (ram_wr_en),
        .wr_idx_i  (idx_q),
        .wr_be_i   (be_q),
        .wr_data_i (wdata_q),
        .rd_en_i   (ram_rd_en),
        .rd_idx_i  (ram_rd_idx),
        .rd_data_o (ram_rd_data)
    );

    assign dmem.ReadData = zero_q ? '0 : ram_rd_data;
    assign dmem.Ack      = ack_q;
    assign dmem.Error    = error_q;
    assign dmem.Busy     = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Four responders (LATENCY 0/1/2 at base 0, and LATENCY 1 with a 16-word
// window at 0x1000) driven by the same request stream and compared every
// cycle against a transaction-level model of the access timing and memory.
module tb_data_mem_responder;

    localparam int NI = 4;

    int          lat_c[NI]   = '{0, 1, 2, 1};
    logic [31:0] base_c[NI]  = '{32'h0, 32'h0, 32'h0, 32'h1000};
    logic [31:0] depth_c[NI] = '{32'd1024, 32'd1024, 32'd1024, 32'd16};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;

    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();
    data_mem_responder_if bus3 ();

    assign bus0.Address = addr; assign bus0.WriteData = wd; assign bus0.ReadEnable = re;
    assign bus0.WriteEnable = we; assign bus0.ByteEnable = be;
    assign bus1.Address = addr; assign bus1.WriteData = wd; assign bus1.ReadEnable = re;
    assign bus1.WriteEnable = we; assign bus1.ByteEnable = be;
    assign bus2.Address = addr; assign bus2.WriteData = wd; assign bus2.ReadEnable = re;
    assign bus2.WriteEnable = we; assign bus2.ByteEnable = be;
    assign bus3.Address = addr; assign bus3.WriteData = wd; assign bus3.ReadEnable = re;
    assign bus3.WriteEnable = we; assign bus3.ByteEnable = be;

    logic [31:0] rd_o[NI];
    logic        ack_o[NI];
    logic        err_o[NI];
    logic        busy_o[NI];

    assign rd_o[0] = bus0.ReadData; assign ack_o[0] = bus0.Ack;
    assign err_o[0] = bus0.Error;   assign busy_o[0] = bus0.Busy;
    assign rd_o[1] = bus1.ReadData; assign ack_o[1] = bus1.Ack;
    assign err_o[1] = bus1.Error;   assign busy_o[1] = bus1.Busy;
    assign rd_o[2] = bus2.ReadData; assign ack_o[2] = bus2.Ack;
    assign err_o[2] = bus2.Error;   assign busy_o[2] = bus2.Busy;
    assign rd_o[3] = bus3.ReadData; assign ack_o[3] = bus3.Ack;
    assign err_o[3] = bus3.Error;   assign busy_o[3] = bus3.Busy;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0))
        u_l0 (.CLK(clk), .RST(rst), .dmem(bus0.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0))
        u_l1 (.CLK(clk), .RST(rst), .dmem(bus1.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0))
        u_l2 (.CLK(clk), .RST(rst), .dmem(bus2.slave));
    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h1000))
        u_b  (.CLK(clk), .RST(rst), .dmem(bus3.slave));

    // Reference model state
    int          edge_n = 0;
    bit          m_act[NI];
    int          m_cap[NI];
    bit          m_wr[NI], m_rd[NI], m_err[NI];
    int          m_idx[NI];
    logic [31:0] m_wd[NI];
    logic [3:0]  m_be[NI];
    logic [31:0] m_rexp[NI], m_rmsk[NI];
    logic [31:0] h_val[NI], h_msk[NI];
    logic [31:0] m_mem[NI][1024];
    logic [3:0]  m_vld[NI][1024];
    bit          e_ack[NI], e_err[NI], e_busy[NI];
    logic [31:0] e_rd[NI], e_msk[NI];

    logic [31:0] last_rd[NI];
    bit          last_err[NI];
    int          ack_cnt[NI];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] v);
        return {{8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}}};
    endfunction

    task automatic model_edge();
        logic [31:0] off;
        edge_n++;
        for (int k = 0; k < NI; k++) begin
            if (!rst) begin
                m_act[k] = 1'b0;
                h_val[k] = '0;
                h_msk[k] = '1;
            end else if (m_act[k] && edge_n == m_cap[k] + lat_c[k] + 1) begin
                if (m_wr[k] && !m_err[k]) begin
                    m_mem[k][m_idx[k]] = (m_mem[k][m_idx[k]] & ~lane_mask(m_be[k]))
                                       | (m_wd[k] & lane_mask(m_be[k]));
                    m_vld[k][m_idx[k]] = m_vld[k][m_idx[k]] | m_be[k];
                end
                m_act[k] = 1'b0;
            end else if (!m_act[k] && (re || we)) begin
                off      = addr - base_c[k];
                m_err[k] = (re && we) || (addr < base_c[k]) || ((off >> 2) >= depth_c[k]);
                m_idx[k] = m_err[k] ? 0 : int'(off >> 2);
                m_wr[k]  = we && !re;
                m_rd[k]  = re && !we;
                m_wd[k]  = wd;
                m_be[k]  = be;
                m_rexp[k] = m_mem[k][m_idx[k]];
                m_rmsk[k] = lane_mask(m_vld[k][m_idx[k]]);
                m_act[k] = 1'b1;
                m_cap[k] = edge_n;
            end
            e_ack[k]  = m_act[k] && edge_n == m_cap[k] + lat_c[k];
            e_busy[k] = m_act[k] && edge_n < m_cap[k] + lat_c[k];
            e_err[k]  = e_ack[k] && m_err[k];
            e_rd[k]   = h_val[k];
            e_msk[k]  = h_msk[k];
            if (e_ack[k]) begin
                if (m_err[k]) begin
                    e_rd[k]  = '0;
                    e_msk[k] = '1;
                    h_msk[k] = '0;
                end else if (m_rd[k]) begin
                    h_val[k] = m_rexp[k];
                    h_msk[k] = m_rmsk[k];
                    e_rd[k]  = h_val[k];
                    e_msk[k] = h_msk[k];
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("ack%0d", k), 32'(ack_o[k]), 32'(e_ack[k]));
            check($sformatf("err%0d", k), 32'(err_o[k]), 32'(e_err[k]));
            check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(e_busy[k]));
            if (e_msk[k] != '0) begin
                check($sformatf("rdata%0d", k), rd_o[k] & e_msk[k], e_rd[k] & e_msk[k]);
            end
            if (e_ack[k]) begin
                ack_cnt[k]++;
                last_err[k] = err_o[k];
                if (!e_err[k]) last_rd[k] = rd_o[k];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_req();
        re = 1'b0; we = 1'b0; be = '0; addr = '0; wd = '0;
    endtask

    task automatic pulse(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        re = r; we = w; be = b; addr = a; wd = d;
        step();
        idle_req();
        repeat (4) step();
    endtask

    task automatic clear_last();
        for (int k = 0; k < NI; k++) begin
            last_rd[k]  = 32'h0BAD_0BAD;
            last_err[k] = 1'b0;
            ack_cnt[k]  = 0;
        end
    endtask

    initial begin
        int r;
        int sel;
        for (int k = 0; k < NI; k++) begin
            m_act[k] = 1'b0;
            h_val[k] = '0;
            h_msk[k] = '0;
            for (int i = 0; i < 1024; i++) begin
                m_mem[k][i] = '0;
                m_vld[k][i] = '0;
            end
        end
        clear_last();

        // Reset
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();

        // Full-word write then read
        pulse(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        clear_last();
        pulse(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        check("deadbeef_l0", last_rd[0], 32'hDEAD_BEEF);
        check("deadbeef_l2", last_rd[2], 32'hDEAD_BEEF);
        check("lowaddr_err_b", 32'(last_err[3]), 32'd1);

        // Byte-lane masking
        pulse(1'b0, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
        pulse(1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        clear_last();
        pulse(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        check("lanes_l1", last_rd[1], 32'h11BB_33DD);
        check("lanes_l2", last_rd[2], 32'h11BB_33DD);

        // Back-to-back on the zero-latency responder
        clear_last();
        re = 1'b0; we = 1'b1; be = 4'hF; addr = 32'h40; wd = 32'h5;
        step();
        idle_req();
        step();
        re = 1'b1; addr = 32'h40;
        step();
        idle_req();
        repeat (4) step();
        check("b2b_l0", last_rd[0], 32'h5);

        // Illegal requests
        clear_last();
        pulse(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
        check("oor_err_l2", 32'(last_err[2]), 32'd1);
        pulse(1'b0, 1'b1, 4'hF, 32'h0, 32'hCAFE_0000);
        clear_last();
        pulse(1'b1, 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
        check("both_err_l0", 32'(last_err[0]), 32'd1);
        clear_last();
        pulse(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        check("both_nowrite_l2", last_rd[2], 32'hCAFE_0000);

        // Reset while the write is outstanding
        pulse(1'b0, 1'b1, 4'hF, 32'h8, 32'h1234);
        re = 1'b0; we = 1'b1; be = 4'hF; addr = 32'h8; wd = 32'h77;
        step();
        idle_req();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (4) step();
        clear_last();
        pulse(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        check("rst_abort_l0", last_rd[0], 32'h1234);
        check("rst_abort_l2", last_rd[2], 32'h1234);

        // Held read enable for ten cycles
        pulse(1'b0, 1'b1, 4'hF, 32'h4, 32'h4444_0004);
        clear_last();
        re = 1'b1; addr = 32'h4;
        repeat (10) step();
        check("held_acks_l0", 32'(ack_cnt[0]), 32'd5);
        check("held_acks_l1", 32'(ack_cnt[1]), 32'd3);
        check("held_acks_l2", 32'(ack_cnt[2]), 32'd2);
        idle_req();
        repeat (4) step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) != 0);
            r   = $urandom_range(0, 9);
            re  = (r >= 4 && r <= 6) || r == 9;
            we  = (r >= 7);
            sel = $urandom_range(0, 9);
            if (sel <= 5)      addr = 32'($urandom_range(0, 15)) << 2;
            else if (sel <= 7) addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            else if (sel == 8) addr = 32'h1040;
            else begin
                case ($urandom_range(0, 2))
                    0:       addr = 32'h4000;
                    1:       addr = 32'hFFFF_FFFC;
                    default: addr = 32'h0FFC;
                endcase
            end
            addr[1:0] = 2'($urandom_range(0, 3));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b1;
        idle_req();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the core's data-memory interface. It accepts word-addressed read and write requests from the memory controller (ReadEnable, WriteEnable, ByteEnable, Address, WriteData) and returns ReadData with a one-cycle Ack pulse after a programmable wait-state count. Byte-lane write masking and an error response for illegal requests are included. It sits between the core's D-memory port and on-chip RAM, and drives the controller's DataMem_Ack input.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2.
LATENCY, 2, wait cycles between request capture and Ack; 0 is legal.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous reset, active-low.
Address  input  32  byte address; bits [1:0] ignored.
WriteData  input  32  write data, lane-aligned.
ReadEnable  input  1  read request.
WriteEnable  input  1  write request.
ByteEnable  input  4  write lane mask; bit i selects byte [8i+7:8i].
ReadData  output  32  read result, valid in the Ack cycle.
Ack  output  1  one-cycle completion pulse.
Error  output  1  qualifies Ack; the request was illegal.
Busy  output  1  high while a request is captured and not yet acked.

Behaviour:
- Reset (RST==0 at an edge): state=IDLE; Ack=0, Error=0, Busy=0, ReadData=0, wait counter=0. Any pending write is discarded. RAM contents are not reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE: if ReadEnable|WriteEnable at an edge, capture Address, WriteData, ByteEnable and op into request registers and set Busy=1.
  - Go to WAIT with counter=LATENCY-1 when LATENCY>0.
  - Go directly to RESP when LATENCY==0.
- WAIT: decrement the counter each cycle. When counter==0, go to RESP. Inputs are ignored in this state.
- RESP: lasts exactly one cycle. Ack=1. Error and ReadData are registered outputs valid in this cycle. Busy=0 in this cycle.
  - Next state is IDLE. A request asserted during RESP is not captured.
  - A request still or newly asserted in the following IDLE cycle starts a new access. The initiator must drop its enables in the Ack cycle to avoid a repeat.
- Latency: request sampled at the end of cycle t gives Ack in cycle t+1+LATENCY.
- Reads: at the edge entering RESP, ReadData is loaded with RAM[captured index]. ReadData holds that value until the next read Ack; write acks leave it unchanged.
- Writes: the lanes with ByteEnable=1 are committed at the edge ending the RESP cycle. ByteEnable==4'b0000 completes with Ack and no change.
  - A read captured immediately after a write Ack returns the new data.
- Error conditions: both enables set at capture, Address<BASE_ADDR, or word index >= DEPTH_WORDS.
  - Response: Ack=1, Error=1, ReadData=0 in that cycle, and no RAM write.
- Index rule: index=(Address-BASE_ADDR)>>2, computed in 32-bit unsigned arithmetic; an underflow yields the out-of-range error.
- If enables drop during WAIT, the captured request completes normally.
- Reset during WAIT or RESP aborts the access: no Ack and no write.

Decomposition:
- Package dmem_pkg holds:
  - dmem_state_t enum {IDLE, WAIT, RESP};
  - WORD_W=32 and BE_W=4;
  - function addr_to_index(addr, base) returning index and a range flag.
- Sub-module byte_ram is natural: a DEPTH_WORDS x 32 synchronous array with a 4-bit lane write mask, one read port and one write port, and no reset.
- data_mem_responder holds the FSM, the request registers, error logic and output registers.

Test Plan:
- LATENCY=2: write 32'hDEAD_BEEF to 0x10 with BE=4'hF, then read 0x10. Ack arrives exactly 3 cycles after each capture, Error=0, and ReadData=32'hDEAD_BEEF in the read Ack cycle.
- Byte lanes: preload 0x20=32'h1122_3344, write 32'hAABB_CCDD with BE=4'b0101. A subsequent read of 0x20 returns 32'h11BB_33DD.
- LATENCY=0, back-to-back: write 0x40=32'h5 (Ack at t+1), then read 0x40 captured at t+2. Ack at t+3 with ReadData=32'h5, and Busy low only in Ack and IDLE cycles.
- Illegal requests: read 0x1000 with DEPTH_WORDS=1024 gives Ack with Error=1 and ReadData=0. ReadEnable=WriteEnable=1 with BE=4'hF at 0x0 gives Error=1, and a later read of 0x0 returns the old value.
- Reset mid-operation: capture a write of 32'h77 to 0x8, assert RST=0 during WAIT for one edge, then release. No Ack appears, Busy=0, and a read of 0x8 returns the pre-write value.
- Held enables: keep ReadEnable=1 at 0x4 for 10 cycles with LATENCY=1. Ack repeats every 3 cycles (capture, WAIT, RESP, with capture in the next IDLE), and nothing is captured in RESP cycles.
